lattice_row_tx: RTL and testbench
=================================

Name: lattice_row_tx

Overview:
- Transmit side of the lattice row-load interface.
- Software writes the initial spin lattice into a local row buffer, one row at a time. On `start`, the block streams rows 0..ROWS-1, in order, to the simulator core over a valid/ready handshake.
- Replaces ad-hoc row pushing with a flow-controlled, restartable loader.
- Spin encoding is bit=1 for up and bit=0 for down, unchanged from the simulator core.

Parameters:
- ROWS, 32, number of lattice rows (power of two, >=2)
- WIDTH, 32, spins per row (bits per row word)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  row-buffer write strobe
- wr_addr  in  $clog2(ROWS)  row index to write
- wr_data  in  WIDTH  row contents
- start  in  1  begin transfer (single-cycle pulse; level also accepted)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last row handshake
- row_valid  out  1  row_data/row_idx/row_last valid
- row_ready  in  1  sink accepts the current row
- row_data  out  WIDTH  current row contents
- row_idx  out  $clog2(ROWS)  index of the current row
- row_last  out  1  high with row_idx==ROWS-1
- spin_up_count  out  $clog2(ROWS*WIDTH+1)  number of 1 bits transmitted (see Optional Feature)

Behaviour:
- Interface: single clock `clk`; synchronous active-high `reset` sampled on the rising edge.
- Reset values:
  - FSM=IDLE, row index=0.
  - busy, done, row_valid and row_last are 0.
  - row_data=0, row_idx=0, spin_up_count=0.
  - All buffer rows are cleared to 0.
- Row buffer: ROWS x WIDTH registers.
  - A write commits at the clock edge when wr_en=1 and the FSM is IDLE or DONE.
  - Writes while in SEND are ignored and the buffer is unchanged.
- FSM states IDLE, SEND, DONE:
  - IDLE: on start=1, go to SEND and set index=0. busy rises in the same edge.
  - SEND:
    - row_valid=1.
    - row_data=buf[index], row_idx=index, row_last=(index==ROWS-1).
    - A handshake occurs when row_valid & row_ready at the clock edge.
    - On handshake with index<ROWS-1, increment index.
    - On handshake with index==ROWS-1, go to DONE.
  - DONE: done=1, busy=0, row_valid=0; return to IDLE the next cycle unconditionally.
- Latency:
  - start accepted at edge N gives row_valid=1 during cycle N+1.
  - With row_ready held at 1, the ROWS rows take exactly ROWS cycles; done asserts in cycle N+ROWS+1.
- Stall: while row_valid=1 and row_ready=0, row_data/row_idx/row_last hold stable and row_valid stays high. row_valid never drops without a handshake, except on reset.
- start while in SEND or DONE is ignored; no restart and no queuing.
- Simultaneous wr_en and start in IDLE: the write commits at that edge. Row 0 presented in cycle N+1 reflects the new data if wr_addr==0.
- Reset mid-transfer returns the block to reset values at that edge, including the cleared buffer. The sink sees row_valid=0 in the next cycle. A partial frame is not completed.
- Index arithmetic is modulo ROWS, but it never wraps in normal operation because of the DONE transition.
- row_ready is ignored outside SEND.

Optional Feature:
- Macro: LATTICE_TX_POPCOUNT_EN.
- Defined:
  - spin_up_count clears to 0 when start is accepted.
  - On each handshake it adds popcount(row_data).
  - The final value is stable from the DONE cycle until the next accepted start or reset. For ROWS=32, WIDTH=32 it ranges 0..1024; magnetization = (2*count-1024)/1024.
- Undefined: the port is present and tied to 0, and no popcount logic is synthesized.

Test Plan:
- Reset, then write rows i=0..31 with wr_data=32'h0000_0001<<i. Pulse start with row_ready=1.
  - Required: rows observed in order, row_idx 0..31, row_data matches, row_last only at idx 31.
  - Required: done pulses exactly 33 cycles after start; with _EN, spin_up_count=32.
- Same load, with row_ready toggled 1,0,0,1 pseudo-randomly.
  - Required: no row is lost or duplicated; row_data/row_idx stay stable during every stall; 32 handshakes total.
- During SEND, issue wr_en to addr 5 with 32'hFFFF_FFFF, plus a second start pulse.
  - Required: transfer unchanged and only 32 rows sent. A re-transfer after done shows the original row 5 (32'h20).
- Assert reset after 10 handshakes.
  - Required: next cycle row_valid=0, busy=0, done=0. A subsequent start sends 32 rows of 0; with _EN, count=0.
- In IDLE, assert wr_en (addr 0, 32'hDEAD_BEEF) and start in the same cycle.
  - Required: the first row is 32'hDEAD_BEEF with row_idx=0.
- All rows 32'hFFFF_FFFF, transfer completed, with _EN.
  - Required: spin_up_count=1024 and held after done. Without the macro it reads 0.

Source files
------------

// File: rtl/lattice_row_tx.sv
// Row-load transmitter: buffers a spin lattice row by row and streams it to the core over valid/ready.
// Optional macro LATTICE_TX_POPCOUNT_EN enables the spin-up (popcount) accumulator on spin_up_count.
module lattice_row_tx #(
  parameter int ROWS  = 32,
  parameter int WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [$clog2(ROWS)-1:0]            wr_addr,
  input  logic [WIDTH-1:0]                   wr_data,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               row_valid,
  input  logic                               row_ready,
  output logic [WIDTH-1:0]                   row_data,
  output logic [$clog2(ROWS)-1:0]            row_idx,
  output logic                               row_last,
  output logic [$clog2(ROWS*WIDTH+1)-1:0]    spin_up_count
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS*WIDTH+1);
  localparam logic [AW-1:0] LAST_IDX = AW'(ROWS-1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0] buf_reg [ROWS];
  logic          wr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND: begin
        if (row_ready) begin
          if (idx_reg == LAST_IDX) state_next = DONE;
          else                     idx_next   = idx_reg + AW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // The buffer is frozen while a frame is in flight so a stalled row stays stable.
  assign wr_ok = wr_en && (state_reg != SEND);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (reset)                                 buf_reg[gi] <= '0;
        else if (wr_ok && (wr_addr == AW'(gi)))    buf_reg[gi] <= wr_data;
      end
    end
  endgenerate

  assign row_valid = (state_reg == SEND);
  assign busy      = (state_reg == SEND);
  assign done      = (state_reg == DONE);
  assign row_idx   = idx_reg;
  assign row_data  = row_valid ? buf_reg[idx_reg] : '0;
  assign row_last  = row_valid && (idx_reg == LAST_IDX);

`ifdef LATTICE_TX_POPCOUNT_EN
  logic [CW-1:0] count_reg;
  logic          accept_start;
  logic          handshake;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + {{(CW-1){1'b0}}, v[i]};
    return c;
  endfunction

  assign accept_start = (state_reg == IDLE) && start;
  assign handshake    = row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (reset)             count_reg <= '0;
    else if (accept_start) count_reg <= '0;
    else if (handshake)    count_reg <= count_reg + popcount(row_data);
  end

  assign spin_up_count = count_reg;
`else
  assign spin_up_count = '0;
`endif

endmodule

// File: tb/tb_lattice_row_tx.sv
// Randomized self-checking bench for lattice_row_tx against a frame-level reference model.
module tb_lattice_row_tx;
  localparam int ROWS  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 11;
`ifdef LATTICE_TX_POPCOUNT_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, wr_en, start, row_ready;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic busy, done, row_valid, row_last;
  logic [WIDTH-1:0] row_data;
  logic [AW-1:0] row_idx;
  logic [CW-1:0] spin_up_count;

  lattice_row_tx #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_idx(row_idx), .row_last(row_last), .spin_up_count(spin_up_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: buffer image, frame phase (0 idle, 1 streaming, 2 finished), next row, ones sent.
  logic [WIDTH-1:0] m_mem [ROWS];
  int m_phase = 0;
  int m_idx = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) m_mem[i] = '0;
      m_phase = 0; m_idx = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      if (start) begin m_phase = 1; m_idx = 0; m_cnt = 0; end
    end else if (m_phase == 1) begin
      if (row_ready) begin
        m_cnt = m_cnt + $countones(m_mem[m_idx]);
        if (m_idx == ROWS-1) m_phase = 2;
        else m_idx = m_idx + 1;
      end
    end else begin
      if (wr_en) m_mem[wr_addr] = wr_data;
      m_phase = 0; m_idx = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy", busy, m_phase == 1);
    chk("done", done, m_phase == 2);
    chk("row_valid", row_valid, m_phase == 1);
    chk("spin_up_count", spin_up_count, POP ? m_cnt : 0);
    if (m_phase == 1) begin
      chk("row_idx", row_idx, m_idx);
      chk("row_data", row_data, m_mem[m_idx]);
      chk("row_last", row_last, m_idx == ROWS-1);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  // Called right after the cycle in which start was accepted; runs until done is seen.
  task automatic run_frame(input bit rnd, input int inject_at, input bit check5,
                           output int hs, output int lat);
    bit seen5 = 1'b0;
    lat = 1; hs = 0;
    while (!done && lat < 2000) begin
      row_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_en = 1'b0; start = 1'b0;
      if (lat == inject_at) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF; start = 1'b1;
      end
      if (check5 && !seen5 && row_valid && row_idx == 5) begin
        chk("row5_original", row_data, 32'h0000_0020);
        seen5 = 1'b1;
      end
      if (row_valid && row_ready) hs++;
      cyc();
      lat++;
    end
    wr_en = 1'b0; start = 1'b0;
    if (!done) chk("frame_timeout", 0, 1);
  endtask

  task automatic kick();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  int hs, lat;

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; row_ready = 1'b0; wr_addr = '0; wr_data = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0); chk("rst_valid", row_valid, 0); chk("rst_data", row_data, 0);
    chk("rst_idx", row_idx, 0); chk("rst_count", spin_up_count, 0);
    reset = 1'b0;

    // Walking-one load, ready held high.
    for (int i = 0; i < ROWS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h0000_0001 << i; cyc();
    end
    wr_en = 1'b0; row_ready = 1'b1;
    kick();
    chk("t1_first_data", row_data, 32'h1); chk("t1_first_idx", row_idx, 0);
    run_frame(1'b0, -1, 1'b0, hs, lat);
    chk("t1_done_latency", lat, 33);
    chk("t1_count", spin_up_count, POP ? 32 : 0);
    cyc();

    // Same load, random back-pressure.
    row_ready = 1'b0;
    kick();
    run_frame(1'b1, -1, 1'b0, hs, lat);
    chk("t2_handshakes", hs, 32);
    cyc();

    // Write and restart attempts during SEND are ignored.
    row_ready = 1'b1;
    kick();
    run_frame(1'b0, 4, 1'b0, hs, lat);
    chk("t3_handshakes", hs, 32);
    cyc();
    kick();
    run_frame(1'b0, -1, 1'b1, hs, lat);
    cyc();

    // Reset after 10 handshakes.
    kick();
    for (int k = 0; k < 10; k++) begin row_ready = 1'b1; cyc(); end
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("t4_valid", row_valid, 0); chk("t4_busy", busy, 0); chk("t4_done", done, 0);
    kick();
    run_frame(1'b1, -1, 1'b0, hs, lat);
    chk("t4_handshakes", hs, 32);
    chk("t4_count", spin_up_count, 0);
    cyc();

    // Write and start in the same IDLE cycle.
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEAD_BEEF;
    kick();
    wr_en = 1'b0;
    chk("t5_first_data", row_data, 32'hDEAD_BEEF); chk("t5_first_idx", row_idx, 0);
    run_frame(1'b1, -1, 1'b0, hs, lat);
    cyc();

    // All spins up.
    for (int i = 0; i < ROWS; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'hFFFF_FFFF; cyc();
    end
    wr_en = 1'b0;
    kick();
    run_frame(1'b1, -1, 1'b0, hs, lat);
    chk("t6_count_done", spin_up_count, POP ? 1024 : 0);
    cyc(); cyc(); cyc();
    chk("t6_count_held", spin_up_count, POP ? 1024 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
